// File: rtl/spi_reg_bridge_if.sv
// Register-side bus between the SPI bridge and the peripheral register block.
//
// Handshake: both strobes are active low and carry the transfer size
// (00 byte, 01 half, 10 word). data_write_n is low for exactly one clk
// cycle, with address/data_in valid in that cycle. data_read_n stays low
// with address valid until the first clk edge where data_ready is high.
// data_out is captured at that edge and the strobe releases on the next cycle.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic [1:0]        data_write_n;
    logic [1:0]        data_read_n;
    logic              data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave that turns serial frames into register reads/writes.
// Frame, MSB first: rw, txn[1:0], address, then 8/16/32 data bits.
// All SPI pins are oversampled by clk through synchroniser chains.
module spi_reg_bridge #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int BURST_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_cs_n,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    spi_reg_bridge_if.master bus,
    output logic             busy,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, DRAIN} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_prev, sclk_prev;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, sclk_rise, sclk_fall;

    logic [1:0]        cmd_sr;
    logic              rw;
    logic [1:0]        txn;
    logic [5:0]        bit_cnt;
    logic [30:0]       wr_sr;
    logic [31:0]       rd_sr;
    logic [15:0]       timer;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_in_q;
    logic [1:0]        write_n_q;
    logic [1:0]        read_n_q;

    logic [2:0]        cmd_full;
    logic [31:0]       wr_full;
    logic [5:0]        nbits;
    logic [ADDR_W-1:0] addr_inc;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cmd_full  = {cmd_sr, mosi_s};
    assign wr_full   = {wr_sr, mosi_s};
    assign addr_inc  = ADDR_W'(32'd1 << txn);

    assign bus.address      = addr_q;
    assign bus.data_in      = data_in_q;
    assign bus.data_write_n = write_n_q;
    assign bus.data_read_n  = read_n_q;

    // Data-phase length in bits for the current transfer size.
    always_comb begin
        nbits = 6'd32;
        case (txn)
            2'b00:   nbits = 6'd8;
            2'b01:   nbits = 6'd16;
            default: nbits = 6'd32;
        endcase
    end

    // Zero the bytes that lie above the transfer size.
    function automatic logic [31:0] mask_word(input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b00:   return {24'd0, d[7:0]};
            2'b01:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Move the transfer's MSB to bit 31 so the read shifter always emits bit 31.
    function automatic logic [31:0] align_word(input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b00:   return {d[7:0], 24'd0};
            2'b01:   return {d[15:0], 16'd0};
            default: return d;
        endcase
    endfunction

    // Synchronisers and edge-detect history. Clearing cs history to 0 means a
    // frame cut by reset can only restart after cs_n has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    // Frame FSM with registered bus, status and miso outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_sr    <= '0;
            rw        <= 1'b0;
            txn       <= 2'b00;
            bit_cnt   <= '0;
            wr_sr     <= '0;
            rd_sr     <= '0;
            timer     <= '0;
            addr_q    <= '0;
            data_in_q <= '0;
            write_n_q <= 2'b11;
            read_n_q  <= 2'b11;
            spi_miso  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            write_n_q <= 2'b11;
            if (state != IDLE && cs_s) begin
                // cs_n high ends the frame wherever it is; pending reads are dropped.
                state    <= IDLE;
                read_n_q <= 2'b11;
                spi_miso <= 1'b0;
                busy     <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_full[1:0];
                            if (bit_cnt == 6'd2) begin
                                rw      <= cmd_full[2];
                                txn     <= cmd_full[1:0];
                                bit_cnt <= '0;
                                state   <= (cmd_full[1:0] == 2'b11) ? DRAIN : ADDR;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_q <= ADDR_W'({addr_q, mosi_s});
                            if (bit_cnt == 6'(ADDR_W - 1)) begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    state <= WDATA;
                                end else begin
                                    state    <= RWAIT;
                                    read_n_q <= txn;
                                    timer    <= '0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    WDATA: begin
                        // Advance the burst address once the strobe cycle is over.
                        if (write_n_q != 2'b11) begin
                            addr_q <= addr_q + addr_inc;
                        end
                        if (sclk_rise) begin
                            wr_sr <= wr_full[30:0];
                            if (bit_cnt == nbits - 6'd1) begin
                                bit_cnt   <= '0;
                                write_n_q <= txn;
                                data_in_q <= mask_word(txn, wr_full);
                                if (BURST_EN == 0) begin
                                    state <= DRAIN;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    RWAIT: begin
                        if (sclk_rise) begin
                            // Master already clocks data: this word goes out as zeros.
                            read_n_q <= 2'b11;
                            rd_sr    <= '0;
                            err      <= 1'b1;
                            bit_cnt  <= 6'd1;
                            state    <= RDATA;
                        end else if (bus.data_ready) begin
                            read_n_q <= 2'b11;
                            rd_sr    <= align_word(txn, mask_word(txn, bus.data_out));
                            bit_cnt  <= '0;
                            state    <= RDATA;
                        end else if (timer == 16'(TIMEOUT - 1)) begin
                            read_n_q <= 2'b11;
                            rd_sr    <= '0;
                            err      <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= RDATA;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            spi_miso <= rd_sr[31];
                            rd_sr    <= rd_sr << 1;
                        end
                        if (sclk_rise) begin
                            if (bit_cnt == nbits - 6'd1) begin
                                bit_cnt  <= '0;
                                spi_miso <= 1'b0;
                                if (BURST_EN != 0) begin
                                    addr_q   <= addr_q + addr_inc;
                                    read_n_q <= txn;
                                    timer    <= '0;
                                    state    <= RWAIT;
                                end else begin
                                    state <= DRAIN;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        // Swallow everything until cs_n rises.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI master driver, register-side
// responder, strobe monitors and expected-value scoreboard.
module tb_spi_reg_bridge;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic busy;
    logic err;

    spi_reg_bridge_if #(.ADDR_W(6)) bus ();

    spi_reg_bridge #(
        .ADDR_W(6), .SYNC_STAGES(2), .TIMEOUT(4), .BURST_EN(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .bus      (bus),
        .busy     (busy),
        .err      (err)
    );

    // clock
    always #5 clk = ~clk;

    // register-side responder: data_ready after ready_lat strobe cycles (0 = never)
    int ready_lat = 3;
    int rd_cycles = 0;
    always @(posedge clk) begin
        if (bus.data_read_n == 2'b11) rd_cycles <= 0;
        else rd_cycles <= rd_cycles + 1;
    end
    assign bus.data_out   = 32'h12345678;
    assign bus.data_ready = (ready_lat != 0) && (bus.data_read_n != 2'b11) && (rd_cycles == ready_lat - 1);

    // monitors: every write-strobe cycle and every read-strobe pulse
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    logic [15:0] obs_rd_q[$];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  rd_info;
    int          rd_len = 0;
    always @(negedge clk) begin
        if (bus.data_write_n != 2'b11)
            obs_q.push_back({bus.data_write_n, bus.address, bus.data_in});
        if (bus.data_read_n != 2'b11) begin
            if (rd_len == 0) rd_info = {bus.data_read_n, bus.address};
            rd_len = rd_len + 1;
        end else if (rd_len > 0) begin
            obs_rd_q.push_back({rd_info, 8'(rd_len)});
            rd_len = 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_compare(input string tag);
        check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        check({tag, "_rd_count"}, 64'(obs_rd_q.size()), 64'(exp_rd_q.size()));
        while (obs_rd_q.size() > 0 && exp_rd_q.size() > 0)
            check({tag, "_rd"}, 64'(obs_rd_q.pop_front()), 64'(exp_rd_q.pop_front()));
        obs_q.delete(); exp_q.delete(); obs_rd_q.delete(); exp_rd_q.delete();
    endtask

    // SPI mode 0 master: drive mosi while sclk low, sample miso just before the rise
    task automatic send_bits(input logic [63:0] bits, input int n, output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            repeat (HALF) @(negedge clk);
            rx = {rx[62:0], spi_miso};
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_write_n"}, 64'(bus.data_write_n), 64'(2'b11));
        check({tag, "_read_n"},  64'(bus.data_read_n),  64'(2'b11));
        check({tag, "_address"}, 64'(bus.address),      64'(0));
        check({tag, "_data_in"}, 64'(bus.data_in),      64'(0));
        check({tag, "_miso"},    64'(spi_miso),         64'(0));
        check({tag, "_busy"},    64'(busy),             64'(0));
        check({tag, "_err"},     64'(err),              64'(0));
    endtask

    logic [63:0] rx;

    initial begin
        // reset
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // word write 0xCAFEF00D to 0x05
        frame_start();
        send_bits({3'b110, 6'h05, 32'hCAFEF00D}, 41, rx);
        check("word_wr_busy", 64'(busy), 64'(1));
        frame_end();
        check("word_wr_busy_after", 64'(busy), 64'(0));
        exp_q.push_back({2'b10, 6'h05, 32'hCAFEF00D});
        sb_compare("word_wr");

        // byte read from 0x10, ready after 3 cycles; burst fetches 0x11 next
        ready_lat = 3;
        frame_start();
        send_bits({3'b000, 6'h10, 8'h00}, 17, rx);
        check("byte_rd_miso", 64'(rx[7:0]), 64'(8'h78));
        frame_end();
        check("byte_rd_err", 64'(err), 64'(0));
        exp_rd_q.push_back({2'b00, 6'h10, 8'd3});
        exp_rd_q.push_back({2'b00, 6'h11, 8'd3});
        sb_compare("byte_rd");

        // half-word burst write wrapping 0x3E -> 0x00
        frame_start();
        send_bits({3'b101, 6'h3E, 16'h1111, 16'h2222}, 41, rx);
        frame_end();
        exp_q.push_back({2'b01, 6'h3E, 32'h00001111});
        exp_q.push_back({2'b01, 6'h00, 32'h00002222});
        sb_compare("half_burst");

        // word read with no data_ready: 4-cycle strobe, zeros out, sticky err
        ready_lat = 0;
        frame_start();
        send_bits({3'b010, 6'h07, 32'h0}, 41, rx);
        check("timeout_miso", 64'(rx[31:0]), 64'(0));
        check("timeout_err_in", 64'(err), 64'(1));
        frame_end();
        check("timeout_err_held", 64'(err), 64'(1));
        exp_rd_q.push_back({2'b10, 6'h07, 8'd4});
        exp_rd_q.push_back({2'b10, 6'h0B, 8'd4});
        sb_compare("timeout");
        ready_lat = 3;

        // write aborted after 20 data bits; new frame clears err
        frame_start();
        check("abort_err_cleared", 64'(err), 64'(0));
        send_bits({3'b110, 6'h01, 20'hABCDE}, 29, rx);
        check("abort_busy_before", 64'(busy), 64'(1));
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_after", 64'(busy), 64'(0));
        repeat (2 * HALF) @(negedge clk);
        sb_compare("abort");

        // reserved transfer size: drained, no strobes
        frame_start();
        send_bits({3'b111, 6'h01, 32'hFFFF0000}, 41, rx);
        check("reserved_busy", 64'(busy), 64'(1));
        frame_end();
        sb_compare("reserved");

        // reset during the address phase, rest of that frame ignored
        frame_start();
        send_bits({3'b110, 3'b101}, 6, rx);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        send_bits({3'b010, 32'h12345678}, 35, rx);
        frame_end();
        sb_compare("mid_rst_ignored");

        // next full frame after the reset
        frame_start();
        send_bits({3'b110, 6'h2A, 32'h0BADBEEF}, 41, rx);
        frame_end();
        exp_q.push_back({2'b10, 6'h2A, 32'h0BADBEEF});
        sb_compare("post_rst_wr");
        check("post_rst_miso", 64'(spi_miso), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
